// File: rtl/e_mdu_if.sv
// E-stage MDU bundle: operation request, forwarded operands, HI/LO state and
// the mfhi/mflo read-back path toward the E-stage result mux.
interface e_mdu_if;
  logic        start;
  logic [3:0]  MDUop;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUResult;

  // Pipeline side: issues MDU instructions and reads results.
  modport master (
    output start, MDUop, srcA, srcB,
    input  busy, HI, LO, MDUResult
  );

  // MDU side: owns HI/LO and the busy flag.
  modport slave (
    input  start, MDUop, srcA, srcB,
    output busy, HI, LO, MDUResult
  );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit. Owns HI/LO, runs mult/multu/div/divu
// as fixed-latency operations on captured operands, and handles mthi/mtlo
// writes and mfhi/mflo reads.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   rst_n,
  e_mdu_if.slave bus
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   cap_a, cap_b;
  op_e           cap_op;

  logic          idle, accept, launch, finish;
  logic          is_mult_op;

  logic [63:0]   prod_s, prod_u;
  logic [31:0]   mag_a, mag_b, mag_q, mag_r;
  logic [31:0]   res_hi, res_lo;
  logic          res_valid;

  // busy depends on the counter register only, never on start/MDUop.
  assign idle       = (cnt == '0);
  assign accept     = bus.start && idle;
  assign is_mult_op = (bus.MDUop == OP_MULT) || (bus.MDUop == OP_MULTU);
  assign launch     = accept && (bus.MDUop >= OP_MULT) && (bus.MDUop <= OP_DIVU);
  assign finish     = (cnt == CW'(1));

  // Completion result computed from the captured operands.
  // NOTE: every variable gets a default at the top so no latch is inferred.
  always_comb begin
    res_hi    = hi_q;
    res_lo    = lo_q;
    res_valid = 1'b0;

    prod_s = 64'($signed(cap_a)) * 64'($signed(cap_b));
    prod_u = 64'(cap_a) * 64'(cap_b);

    // Signed divide is done on magnitudes so the 0x80000000 / -1 corner
    // falls out naturally (magnitude 2^31, negated back to 0x80000000).
    mag_a = (cap_op == OP_DIV && cap_a[31]) ? (~cap_a + 32'd1) : cap_a;
    mag_b = (cap_op == OP_DIV && cap_b[31]) ? (~cap_b + 32'd1) : cap_b;
    mag_q = (mag_b != '0) ? (mag_a / mag_b) : '0;
    mag_r = (mag_b != '0) ? (mag_a % mag_b) : '0;

    unique case (cap_op)
      OP_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_valid        = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_valid        = 1'b1;
      end
      OP_DIV: begin
        res_lo    = (cap_a[31] ^ cap_b[31]) ? (~mag_q + 32'd1) : mag_q;
        res_hi    = cap_a[31] ? (~mag_r + 32'd1) : mag_r;
        res_valid = (cap_b != '0);
      end
      OP_DIVU: begin
        res_lo    = mag_q;
        res_hi    = mag_r;
        res_valid = (cap_b != '0);
      end
      default: ;
    endcase
  end

  // Operand capture, countdown and HI/LO update.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cap_a  <= '0;
      cap_b  <= '0;
      cap_op <= OP_NONE;
    end else begin
      if (!idle) begin
        cnt <= cnt - CW'(1);
      end

      if (launch) begin
        cap_a  <= bus.srcA;
        cap_b  <= bus.srcB;
        cap_op <= op_e'(bus.MDUop);
        cnt    <= is_mult_op ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end

      // finish only happens while busy, so it never collides with mthi/mtlo.
      if (finish && res_valid) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end

      if (accept && bus.MDUop == OP_MTHI) begin
        hi_q <= bus.srcA;
      end
      if (accept && bus.MDUop == OP_MTLO) begin
        lo_q <= bus.srcA;
      end
    end
  end

  assign bus.busy      = !idle;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.MDUResult = (bus.MDUop == OP_MFHI) ? hi_q :
                         (bus.MDUop == OP_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases followed by random
// operations compared against an arithmetic reference model of HI/LO.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] m_hi, m_lo;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: HI/LO after an accepted op, from plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint sp;
    longint unsigned up;
    sa = a;
    sb = b;
    case (op)
      4'd1: begin sp = longint'(sa) * longint'(sb); m_hi = sp[63:32]; m_lo = sp[31:0]; end
      4'd2: begin up = {32'h0, a} * {32'h0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'h0;
        end else begin
          m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
        end
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.MDUop = op;
    bus.srcA  = a;
    bus.srcB  = b;
    step();
    bus.start = 1'b0;
    bus.MDUop = 4'd0;
  endtask

  // Counts busy cycles (bounded); optionally scrambles non-start inputs.
  task automatic wait_done(input string tag, input int exp_n, input bit scramble);
    int c;
    c = 0;
    while (bus.busy === 1'b1 && c < 100) begin
      c++;
      if (scramble) begin
        bus.srcA  = $urandom;
        bus.srcB  = $urandom;
        bus.MDUop = 4'($urandom_range(0, 15));
      end
      step();
    end
    bus.MDUop = 4'd0;
    check({tag, "_busy_cycles"}, 32'(c), 32'(exp_n));
  endtask

  task automatic verify(input string tag);
    check({tag, "_hi"}, bus.HI, m_hi);
    check({tag, "_lo"}, bus.LO, m_lo);
    bus.MDUop = 4'd5; #1;
    check({tag, "_mfhi"}, bus.MDUResult, m_hi);
    bus.MDUop = 4'd6; #1;
    check({tag, "_mflo"}, bus.MDUResult, m_lo);
    bus.MDUop = 4'd0; #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit scramble);
    issue(op, a, b);
    if (op >= 4'd1 && op <= 4'd4) begin
      wait_done(tag, (op <= 4'd2) ? MULT_N : DIV_N, scramble);
    end else begin
      check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    end
    model(op, a, b);
    verify(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_hi  = '0;
    m_lo  = '0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.MDUop = 4'd0;
    bus.srcA  = '0;
    bus.srcB  = '0;

    // Reset state.
    step();
    step();
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_hi", bus.HI, 32'h0);
    check("rst_lo", bus.LO, 32'h0);
    rst_n = 1'b1;
    step();

    // mult vs multu.
    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mult_hi_const", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.LO, 32'hFFFF_FFFE);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multu_hi_const", bus.HI, 32'h0000_0001);
    check("multu_lo_const", bus.LO, 32'hFFFF_FFFE);

    // div signs.
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lo_const", bus.LO, 32'hFFFF_FFFD);
    check("div_hi_const", bus.HI, 32'hFFFF_FFFF);
    run_op("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("divu_lo_const", bus.LO, 32'h7FFF_FFFC);
    check("divu_hi_const", bus.HI, 32'h0000_0001);

    // Boundary divides.
    run_op("mthi", 4'd7, 32'h1111, 32'h0, 1'b0);
    run_op("mtlo", 4'd8, 32'h2222, 32'h0, 1'b0);
    run_op("div0", 4'd3, 32'h1234_5678, 32'h0, 1'b0);
    check("div0_hi_const", bus.HI, 32'h1111);
    check("div0_lo_const", bus.LO, 32'h2222);
    run_op("divu0", 4'd4, 32'h1234_5678, 32'h0, 1'b0);
    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("divovf_lo_const", bus.LO, 32'h8000_0000);
    check("divovf_hi_const", bus.HI, 32'h0);

    // Operand capture and ignore-while-busy.
    issue(4'd2, 32'd3, 32'd4);
    bus.start = 1'b1;
    bus.MDUop = 4'd7;
    bus.srcA  = 32'd7;
    bus.srcB  = 32'd7;
    step();
    bus.start = 1'b0;
    wait_done("ignore", MULT_N - 1, 1'b0);
    check("ignore_hi", bus.HI, 32'h0);
    check("ignore_lo", bus.LO, 32'd12);
    m_hi = 32'h0;
    m_lo = 32'd12;

    // Back-to-back: mtlo at the first idle edge.
    issue(4'd2, 32'd3, 32'd4);
    wait_done("b2b", MULT_N, 1'b0);
    bus.MDUop = 4'd6; #1;
    check("b2b_mflo_first", bus.MDUResult, 32'd12);
    bus.start = 1'b1;
    bus.MDUop = 4'd8;
    bus.srcA  = 32'h55;
    step();
    bus.start = 1'b0;
    bus.MDUop = 4'd6; #1;
    check("b2b_lo_next", bus.LO, 32'h55);
    check("b2b_mflo_next", bus.MDUResult, 32'h55);
    m_lo = 32'h55;

    // Non-launching requests leave state alone.
    run_op("op_none", 4'd0, 32'hDEAD_BEEF, 32'h1, 1'b0);
    run_op("op_12", 4'd12, 32'hDEAD_BEEF, 32'h1, 1'b0);
    bus.MDUop = 4'd7;
    bus.srcA  = 32'hCAFE;
    step();
    bus.MDUop = 4'd1;
    step();
    bus.MDUop = 4'd0;
    check("nostart_busy", 32'(bus.busy), 32'h0);
    verify("nostart");

    // Random operations, inputs scrambled while busy.
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 8));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b, 1'b1);
    end

    // Asynchronous reset mid-divide with counter at 4.
    run_op("pre_rst", 4'd7, 32'hAAAA, 32'h0, 1'b0);
    issue(4'd3, 32'd100, 32'd7);
    repeat (6) step();
    check("mid_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_hi", bus.HI, 32'h0);
    check("arst_lo", bus.LO, 32'h0);
    #1;
    rst_n = 1'b1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    step();
    check("post_rst_busy", 32'(bus.busy), 32'h0);
    verify("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
